fli_wb_arb: RTL and testbench
=============================

Name: fli_wb_arb

Overview:
- Buffers fli (float-immediate load) results and schedules them onto the shared FP register-file write port, which they share with the main FPU result path.
- Drives the index and format into the combinational fli immediate generator, captures the NaN-boxed immediate into a small FIFO, then arbitrates each cycle between FPU writeback and queued fli writes.
- Starvation control guarantees forward progress for fli.
- Scoreboard output lets the hazard unit stall readers of pending destinations.

Parameters:
- FLEN, 64, FP register width (width of immediate and write data).
- DEPTH, 4, fli FIFO entries (power of 2, >=2).
- STARVE, 3, max consecutive FPU grants while the FIFO is non-empty before fli is forced (>=1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- FliValid  in  1  fli request
- FliRs1  in  5  immediate index
- FliFmt  in  2  format (00 S, 01 D, 10 H, 11 Q)
- FliRd  in  5  destination FP register
- FliReady  out  1  request accepted this cycle when FliValid=1
- FliIdx  out  5  index to immediate generator (=FliRs1)
- FliFmtSel  out  2  format to immediate generator (=FliFmt)
- FliImm  in  FLEN  immediate returned combinationally by generator
- FpuValid  in  1  FPU result ready for writeback
- FpuRd  in  5  FPU destination
- FpuRes  in  FLEN  FPU result
- FpuStall  out  1  FPU lost arbitration; hold FpuValid/FpuRd/FpuRes
- Flush  in  1  discard all queued fli entries
- Query  in  5  register queried by hazard unit
- QueryHit  out  1  some queued entry has Rd==Query
- FliCount  out  $clog2(DEPTH+1)  queued entries
- FRegWrite  out  1  register-file write enable
- FRegAdr  out  5  write address
- FRegWD  out  FLEN  write data

Behaviour:
- Reset:
  - FIFO empty, pointers and starvation counter 0.
  - FRegWrite=0, FRegAdr=0, FRegWD=0, FliCount=0.
  - FliReady=0 while reset is high. FpuStall=0 and QueryHit=0 (queue empty).
- Enqueue:
  - FliReady = ~reset & (FliCount!=DEPTH) & ~Flush.
  - On FliValid&FliReady, {FliRd, FliImm} is written at the tail at the clock edge.
  - FliIdx/FliFmtSel are pure wires from FliRs1/FliFmt.
  - When full, FliReady stays low even if a dequeue occurs that cycle (no full-bypass). Requests are not dropped: the requester holds FliValid.
- Eligibility: an entry enqueued in cycle N is first eligible for grant in cycle N+1. There is no empty-bypass.
- Arbitration, each cycle, with E = FIFO non-empty:
  - FpuValid & ~E: FPU granted, starvation counter cleared.
  - ~FpuValid & E: head entry granted and dequeued, counter cleared.
  - FpuValid & E & counter<STARVE: FPU granted, counter+1.
  - FpuValid & E & counter==STARVE: fli granted and dequeued, FpuStall=1, counter cleared.
  - Neither: no grant, counter cleared.
- FpuStall is combinational and asserts only in the forced-fli case.
- Write port:
  - Registered. A grant in cycle N gives FRegWrite=1 with the winner's Rd and data in cycle N+1.
  - With no grant, FRegWrite=0 and FRegAdr/FRegWD hold their previous values.
  - Total fli latency from accepted request to FRegWrite is 2 cycles when uncontended.
- Ordering: fli entries are written strictly FIFO. No fli/FPU ordering is guaranteed; the hazard unit uses QueryHit.
- Flush:
  - Clears the FIFO and the counter at the edge.
  - Blocks enqueue that cycle (FliReady=0) and suppresses any fli grant that cycle.
  - An FPU grant in the same cycle proceeds normally.
  - A write already in the output register still completes.
- QueryHit: combinational OR over valid entries of (Rd==Query). An entry granted this cycle still counts until it leaves the FIFO at the edge.
- FliCount: next = count + enq − deq. Simultaneous enq/deq leaves it unchanged; pointers wrap modulo DEPTH.
- Reset mid-operation: all state is discarded and FRegWrite=0 on the cycle after reset is sampled. In-flight fli entries are lost.

Test Plan:
- After reset: FliValid, FliRs1=16, FliFmt=00, FliRd=5, generator returns 0xFFFFFFFF3F800000, FpuValid=0 -> FliReady=1 in cycle 0; FRegWrite=1, FRegAdr=5, FRegWD=0xFFFFFFFF3F800000 in cycle 2; FliCount 1 then 0.
- Four back-to-back requests (Rd 1..4) while FpuValid=1 with STARVE=3 -> FliReady=0 on the 5th; FpuStall=1 every 4th cycle; FRegAdr sequence 1,2,3,4 interleaved with FPU writes.
- FpuValid held with Rd=9, one fli entry queued -> three FPU writes to f9, then FpuStall=1 and a fli write, then FPU resumes.
- Three entries queued plus Flush together with FliValid -> FliReady=0, FliCount=0 next cycle, no fli writes follow, FPU writes are unaffected.
- Entries with Rd 7 and 12 queued; Query=12 -> QueryHit=1; Query=3 -> QueryHit=0; after Rd 12 is dequeued, Query=12 -> QueryHit=0.
- Reset asserted with 2 entries queued and a write pending -> FRegWrite=0, FliCount=0, FliReady=0 during reset; FliReady=1 in the first cycle after deassertion.

Source files
------------

// File: rtl/fli_wb_arb.sv
// fli_wb_arb: queues fli immediates and shares the FP register-file write port
// with the FPU result path. FPU normally wins; a starvation counter forces an
// fli write after STARVE consecutive FPU wins while fli work is waiting.
module fli_wb_arb #(
  parameter int FLEN   = 64,
  parameter int DEPTH  = 4,
  parameter int STARVE = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       FliValid,
  input  logic [4:0]                 FliRs1,
  input  logic [1:0]                 FliFmt,
  input  logic [4:0]                 FliRd,
  output logic                       FliReady,
  output logic [4:0]                 FliIdx,
  output logic [1:0]                 FliFmtSel,
  input  logic [FLEN-1:0]            FliImm,
  input  logic                       FpuValid,
  input  logic [4:0]                 FpuRd,
  input  logic [FLEN-1:0]            FpuRes,
  output logic                       FpuStall,
  input  logic                       Flush,
  input  logic [4:0]                 Query,
  output logic                       QueryHit,
  output logic [$clog2(DEPTH+1)-1:0] FliCount,
  output logic                       FRegWrite,
  output logic [4:0]                 FRegAdr,
  output logic [FLEN-1:0]            FRegWD
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int SW = $clog2(STARVE+1);

  logic [4:0]      rd_q  [DEPTH];
  logic [4:0]      rd_d  [DEPTH];
  logic [FLEN-1:0] imm_q [DEPTH];
  logic [FLEN-1:0] imm_d [DEPTH];
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [SW-1:0]   starve_q, starve_d;
  logic            we_q, we_d;
  logic [4:0]      adr_q, adr_d;
  logic [FLEN-1:0] wd_q, wd_d;

  logic non_empty, enq, fpu_gnt, fli_gnt, query_hit;
  logic [PW-1:0] off;

  assign FliIdx    = FliRs1;
  assign FliFmtSel = FliFmt;
  assign FliCount  = count_q;
  assign FRegWrite = we_q;
  assign FRegAdr   = adr_q;
  assign FRegWD    = wd_q;

  // Accept/arbitrate: a flushing queue is treated as empty so only FPU can win.
  always_comb begin
    non_empty = (count_q != '0) & ~Flush;
    FliReady  = ~reset & (count_q != CW'(DEPTH)) & ~Flush;
    enq       = FliValid & FliReady;
    fpu_gnt   = 1'b0;
    fli_gnt   = 1'b0;
    starve_d  = '0;
    if (!reset) begin
      if (FpuValid && !non_empty) begin
        fpu_gnt = 1'b1;
      end else if (!FpuValid && non_empty) begin
        fli_gnt = 1'b1;
      end else if (FpuValid && non_empty) begin
        if (starve_q < SW'(STARVE)) begin
          fpu_gnt  = 1'b1;
          starve_d = starve_q + SW'(1);
        end else begin
          fli_gnt = 1'b1;
        end
      end
    end
    FpuStall = fli_gnt & FpuValid;
  end

  // FIFO pointer, occupancy and storage next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    rd_d    = rd_q;
    imm_d   = imm_q;
    if (Flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) begin
        rd_d[tail_q]  = FliRd;
        imm_d[tail_q] = FliImm;
        tail_d        = tail_q + PW'(1);
      end
      if (fli_gnt) head_d = head_q + PW'(1);
      count_d = count_q + CW'(enq) - CW'(fli_gnt);
    end
  end

  // Write-port register: load the winner, otherwise hold address/data.
  always_comb begin
    we_d  = fpu_gnt | fli_gnt;
    adr_d = adr_q;
    wd_d  = wd_q;
    if (fpu_gnt) begin
      adr_d = FpuRd;
      wd_d  = FpuRes;
    end else if (fli_gnt) begin
      adr_d = rd_q[head_q];
      wd_d  = imm_q[head_q];
    end
  end

  // Hazard lookup over occupied slots; the head being granted still counts.
  always_comb begin
    query_hit = 1'b0;
    off       = '0;
    for (int j = 0; j < DEPTH; j++) begin
      off = PW'(j) - head_q;
      if ((CW'(off) < count_q) && (rd_q[j] == Query)) query_hit = 1'b1;
    end
    QueryHit = query_hit & ~reset;
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wd_q     <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wd_q     <= wd_d;
    end
  end

  // Entry payload storage; validity lives entirely in the pointers and count.
  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    imm_q <= imm_d;
  end

endmodule

// File: tb/tb_fli_wb_arb.sv
module tb_fli_wb_arb;
  localparam int FLEN = 64, DEPTH = 4, STARVE = 3;

  logic clk = 1'b0;
  logic reset, FliValid, FpuValid, Flush;
  logic [4:0] FliRs1, FliRd, FpuRd, Query;
  logic [1:0] FliFmt;
  logic [FLEN-1:0] FliImm, FpuRes;
  logic FliReady, FpuStall, QueryHit, FRegWrite;
  logic [4:0] FliIdx, FRegAdr;
  logic [1:0] FliFmtSel;
  logic [$clog2(DEPTH+1)-1:0] FliCount;
  logic [FLEN-1:0] FRegWD;

  fli_wb_arb #(.FLEN(FLEN), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
    .clk(clk), .reset(reset), .FliValid(FliValid), .FliRs1(FliRs1), .FliFmt(FliFmt),
    .FliRd(FliRd), .FliReady(FliReady), .FliIdx(FliIdx), .FliFmtSel(FliFmtSel),
    .FliImm(FliImm), .FpuValid(FpuValid), .FpuRd(FpuRd), .FpuRes(FpuRes),
    .FpuStall(FpuStall), .Flush(Flush), .Query(Query), .QueryHit(QueryHit),
    .FliCount(FliCount), .FRegWrite(FRegWrite), .FRegAdr(FRegAdr), .FRegWD(FRegWD));

  always #5 clk = ~clk;

  function automatic logic [63:0] gen(logic [4:0] i, logic [1:0] f);
    if (i == 5'd16 && f == 2'd0) return 64'hFFFFFFFF3F800000;
    return 64'hC0DE000000000000 | {57'd0, f, i};
  endfunction

  assign FliImm = gen(FliIdx, FliFmtSel);

  typedef struct { logic [4:0] rd; logic [63:0] imm; } ent_t;
  ent_t q[$];
  int starve = 0;
  logic m_we = 1'b0;
  logic [4:0] m_adr = '0;
  logic [63:0] m_wd = '0;
  bit last_stall = 0, last_acc = 0;
  int n_vec = 0, n_fail = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: compare against the queue model, advance the model, move to next negedge.
  task automatic tick();
    bit ready, e, fpu_g, fli_g, stall, hit;
    ent_t h;
    #1;
    ready = !reset && q.size() != DEPTH && !Flush;
    e     = q.size() > 0 && !Flush;
    fpu_g = 0; fli_g = 0;
    if (!reset) begin
      if (FpuValid && (!e || starve < STARVE)) fpu_g = 1;
      else if (e) fli_g = 1;
    end
    stall = fli_g && FpuValid;
    hit = 0;
    if (!reset) foreach (q[i]) if (q[i].rd == Query) hit = 1;
    chk("FliReady", 64'(FliReady), 64'(ready));
    chk("FpuStall", 64'(FpuStall), 64'(stall));
    chk("QueryHit", 64'(QueryHit), 64'(hit));
    chk("FliCount", 64'(FliCount), 64'(q.size()));
    chk("FRegWrite", 64'(FRegWrite), 64'(m_we));
    chk("FRegAdr", 64'(FRegAdr), 64'(m_adr));
    chk("FRegWD", FRegWD, m_wd);
    chk("FliIdx", 64'(FliIdx), 64'(FliRs1));
    chk("FliFmtSel", 64'(FliFmtSel), 64'(FliFmt));
    if (reset) begin
      q.delete(); starve = 0; m_we = 0; m_adr = '0; m_wd = '0;
    end else begin
      if (fpu_g) begin
        m_we = 1; m_adr = FpuRd; m_wd = FpuRes;
      end else if (fli_g) begin
        h = q.pop_front(); m_we = 1; m_adr = h.rd; m_wd = h.imm;
      end else m_we = 0;
      starve = (fpu_g && e) ? starve + 1 : 0;
      if (Flush) q.delete();
      if (FliValid && ready) q.push_back('{FliRd, gen(FliRs1, FliFmt)});
    end
    last_stall = stall;
    last_acc   = FliValid && ready;
    @(negedge clk);
  endtask

  initial begin
    reset = 1; FliValid = 0; FliRs1 = 0; FliFmt = 0; FliRd = 0;
    FpuValid = 0; FpuRd = 0; FpuRes = '0; Flush = 0; Query = 0;
    @(negedge clk);
    #1 chk("lit_ready_in_reset", 64'(FliReady), 64'd0);
    tick(); tick();
    reset = 0;

    // single uncontended fli
    FliValid = 1; FliRs1 = 16; FliFmt = 0; FliRd = 5;
    #1 chk("lit_ready_c0", 64'(FliReady), 64'd1);
    tick();
    FliValid = 0;
    chk("lit_count_c1", 64'(FliCount), 64'd1);
    tick();
    chk("lit_we_c2", 64'(FRegWrite), 64'd1);
    chk("lit_adr_c2", 64'(FRegAdr), 64'd5);
    chk("lit_wd_c2", FRegWD, 64'hFFFFFFFF3F800000);
    chk("lit_count_c2", 64'(FliCount), 64'd0);
    tick();

    // starvation: FPU to f9 held, one fli queued
    FpuValid = 1; FpuRd = 9; FpuRes = 64'h9999; FliValid = 1; FliRs1 = 1; FliRd = 3;
    tick();
    FliValid = 0;
    for (int k = 0; k < 4; k++) begin
      #1 chk("lit_starve_stall", 64'(FpuStall), 64'(k == 3));
      tick();
    end
    chk("lit_forced_adr", 64'(FRegAdr), 64'd3);
    tick();
    chk("lit_fpu_resume", 64'(FRegAdr), 64'd9);
    FpuValid = 0; tick();

    // query hits
    FpuValid = 1; FpuRd = 1; FliValid = 1; FliRd = 7; tick();
    FliRd = 12; tick();
    FliValid = 0; Query = 12;
    #1 chk("lit_hit12", 64'(QueryHit), 64'd1);
    Query = 3;
    #1 chk("lit_hit3", 64'(QueryHit), 64'd0);
    tick();
    FpuValid = 0; tick();
    Query = 12;
    #1 chk("lit_hit12_granted", 64'(QueryHit), 64'd1);
    tick();
    #1 chk("lit_hit12_gone", 64'(QueryHit), 64'd0);

    // flush with three queued and a concurrent request
    FpuValid = 1; FpuRd = 20; FliValid = 1;
    for (int k = 1; k <= 3; k++) begin FliRd = 5'(k); tick(); end
    Flush = 1;
    #1 chk("lit_ready_flush", 64'(FliReady), 64'd0);
    tick();
    Flush = 0; FliValid = 0;
    chk("lit_count_flush", 64'(FliCount), 64'd0);
    chk("lit_adr_flush", 64'(FRegAdr), 64'd20);
    tick(); tick();
    FpuValid = 0; tick();

    // reset with entries queued and a write pending
    FpuValid = 1; FliValid = 1; FliRd = 4; tick(); tick();
    reset = 1; FliValid = 0; FpuValid = 0; tick();
    chk("lit_we_reset", 64'(FRegWrite), 64'd0);
    chk("lit_count_reset", 64'(FliCount), 64'd0);
    tick();
    reset = 0; FliValid = 1;
    #1 chk("lit_ready_after_reset", 64'(FliReady), 64'd1);
    tick();
    FliValid = 0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      Flush = ($urandom_range(0, 24) == 0);
      if (!last_stall) begin
        FpuValid = ($urandom_range(0, 2) != 0);
        FpuRd    = 5'($urandom_range(0, 7));
        FpuRes   = {$urandom, $urandom};
      end
      if (!(FliValid && !last_acc)) begin
        FliValid = 1'($urandom_range(0, 1));
        FliRs1   = 5'($urandom);
        FliFmt   = 2'($urandom);
        FliRd    = 5'($urandom_range(0, 7));
      end
      Query = 5'($urandom_range(0, 7));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
